// File: rtl/instr_sequencer.sv
// instr_sequencer: loads a 32-element job, runs the array, then streams 16 results out
module instr_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int RUN_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [15:0]           instruction,
    input  logic [DATA_WIDTH-1:0] result_in,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, STOP, ST_ADDR, ST_WAIT, DONE} state_t;
    localparam logic [15:0] W_STOP  = 16'h4000;
    localparam logic [15:0] W_START = 16'h0000;
    state_t                  state_q;
    logic [4:0]              idx_q;
    logic [3:0]              cnt_q;
    logic [3:0]              sidx_q;
    logic [3:0]              sidx_d;
    logic [15:0]             instr_q;
    logic [DATA_WIDTH-1:0]   res_data_q;
    logic                    res_valid_q;
    logic [7:0]              imm;
    logic [15:0]             load_w;
    assign sidx_d      = sidx_q + 4'd1;
    assign imm         = 8'(in_data);
    assign load_w      = {2'b10, idx_q[4], 1'b0, idx_q[3:0], imm};
    assign in_ready    = state_q == LOAD;
    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
    assign instruction = instr_q;
    assign res_data    = res_data_q;
    assign res_valid   = res_valid_q;
    // STORE word addressing row/col sidx[3:2]/sidx[1:0] of matrix A
    function automatic logic [15:0] store_word(input logic [3:0] s);
        return {4'b1100, s, 8'h00};
    endfunction
    // sequencer FSM; instruction is loaded on each edge with the word for the coming cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            sidx_q      <= '0;
            instr_q     <= W_STOP;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    instr_q <= W_STOP;
                    if (go) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        sidx_q  <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        instr_q <= load_w;
                        if (idx_q == 5'd31) state_q <= RUN;
                        else idx_q <= idx_q + 5'd1;
                    end else begin
                        instr_q <= W_STOP;
                    end
                end
                RUN: begin
                    if (cnt_q == 4'(RUN_CYCLES)) begin
                        state_q <= STOP;
                        instr_q <= W_STOP;
                    end else begin
                        instr_q <= W_START;
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                STOP: begin
                    state_q <= ST_ADDR;
                    instr_q <= store_word(sidx_q);
                end
                ST_ADDR: begin
                    res_data_q  <= result_in;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (sidx_q == 4'd15) begin
                            state_q <= DONE;
                            instr_q <= W_STOP;
                        end else begin
                            sidx_q  <= sidx_d;
                            state_q <= ST_ADDR;
                            instr_q <= store_word(sidx_d);
                        end
                    end
                end
                DONE: begin
                    instr_q <= W_STOP;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed checks of load, run, store and reset behaviour
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instruction;
    logic [7:0]  result_in;
    logic [7:0]  res_data;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic        done;
    int          n_cmp = 0;
    int          n_err = 0;

    instr_sequencer #(.DATA_WIDTH(8), .RUN_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .instruction(instruction), .result_in(result_in),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // array model: element 11 returns 0x5A, others 0x3<addr>
    assign result_in = (instruction[11:8] == 4'd11) ? 8'h5A : {4'h3, instruction[11:8]};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] data_of(input int i);
        if (i == 5) return 8'h12;
        if (i == 16) return 8'hAB;
        return 8'(i * 3 + 1);
    endfunction

    function automatic logic [7:0] res_of(input int s);
        return (s == 11) ? 8'h5A : 8'(8'h30 + s);
    endfunction

    task automatic test_reset;
        n_cmp++; if (instruction !== 16'h4000) begin n_err++; $display("FAIL reset_instr got %h want 4000", instruction); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_cmp++; if (res_data !== 8'h00) begin n_err++; $display("FAIL reset_res_data got %h want 00", res_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_go;
        go = 1'b1;
        tick;
        go = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL go_in_ready got %b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL go_busy got %b want 1", busy); end
    endtask

    task automatic test_load(input bit gaps);
        logic [15:0] exp;
        for (int i = 0; i < 32; i++) begin
            if (gaps && (i % 7 == 3)) begin
                in_valid = 1'b0;
                in_data  = 8'hFF;
                tick;
                n_cmp++; if (instruction !== 16'h4000) begin n_err++; $display("FAIL load_gap idx %0d got %h want 4000", i, instruction); end
            end
            in_valid = 1'b1;
            in_data  = data_of(i);
            tick;
            exp = 16'h8000 | (i >= 16 ? 16'h2000 : 16'h0000) | 16'((i % 16) << 8) | 16'(data_of(i));
            n_cmp++; if (instruction !== exp) begin n_err++; $display("FAIL load_word idx %0d got %h want %h", i, instruction, exp); end
            if (i == 5) begin
                n_cmp++; if (instruction !== 16'h8512) begin n_err++; $display("FAIL load_idx5 got %h want 8512", instruction); end
            end
            if (i == 16) begin
                n_cmp++; if (instruction !== 16'hA0AB) begin n_err++; $display("FAIL load_idx16 got %h want A0AB", instruction); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL load_end_in_ready got %b want 0", in_ready); end
    endtask

    task automatic test_run;
        go       = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int k = 1; k <= 10; k++) begin
            tick;
            n_cmp++; if (instruction !== 16'h0000) begin n_err++; $display("FAIL run_start cycle %0d got %h want 0000", k, instruction); end
        end
        tick;
        n_cmp++; if (instruction !== 16'h4000) begin n_err++; $display("FAIL run_stop got %h want 4000", instruction); end
        go       = 1'b0;
        in_valid = 1'b0;
        tick;
        n_cmp++; if (instruction !== 16'hC000) begin n_err++; $display("FAIL run_first_store got %h want C000", instruction); end
    endtask

    task automatic test_store(input int first);
        logic [15:0] exp;
        int          pulses;
        res_ready = 1'b1;
        pulses    = 0;
        for (int s = first; s < 16; s++) begin
            exp = 16'hC000 | 16'(s << 8);
            n_cmp++; if (instruction !== exp) begin n_err++; $display("FAIL store_addr sidx %0d got %h want %h", s, instruction, exp); end
            n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL store_addr_valid sidx %0d got %b want 0", s, res_valid); end
            tick;
            n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL store_valid sidx %0d got %b want 1", s, res_valid); end
            n_cmp++; if (res_data !== res_of(s)) begin n_err++; $display("FAIL store_data sidx %0d got %h want %h", s, res_data, res_of(s)); end
            n_cmp++; if (instruction !== exp) begin n_err++; $display("FAIL store_wait_word sidx %0d got %h want %h", s, instruction, exp); end
            if (s == 11) begin
                n_cmp++; if (instruction !== 16'hCB00 || res_data !== 8'h5A) begin n_err++; $display("FAIL store_11 got %h/%h want CB00/5A", instruction, res_data); end
            end
            if (done) pulses++;
            tick;
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL done_pulse got %b want 1", done); end
        n_cmp++; if (instruction !== 16'h4000) begin n_err++; $display("FAIL done_word got %h want 4000", instruction); end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL done_early got %0d want 0", pulses); end
        tick;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_fall got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_fall got %b want 0", busy); end
        n_cmp++; if (instruction !== 16'h4000) begin n_err++; $display("FAIL idle_word got %h want 4000", instruction); end
    endtask

    task automatic test_store_stall;
        res_ready = 1'b0;
        tick;
        for (int c = 0; c < 5; c++) begin
            tick;
            n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid cycle %0d got %b want 1", c, res_valid); end
            n_cmp++; if (res_data !== 8'h30) begin n_err++; $display("FAIL stall_data cycle %0d got %h want 30", c, res_data); end
            n_cmp++; if (instruction !== 16'hC000) begin n_err++; $display("FAIL stall_word cycle %0d got %h want C000", c, instruction); end
        end
        res_ready = 1'b1;
        tick;
        n_cmp++; if (instruction !== 16'hC100) begin n_err++; $display("FAIL stall_release got %h want C100", instruction); end
    endtask

    task automatic test_reset_mid_run;
        test_go;
        test_load(1'b0);
        repeat (3) tick;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (instruction !== 16'h4000) begin n_err++; $display("FAIL midrst_word got %h want 4000", instruction); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
        tick;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) tick;
        n_cmp++; if (in_ready !== 1'b0 || instruction !== 16'h4000) begin n_err++; $display("FAIL midrst_nogo got %b/%h want 0/4000", in_ready, instruction); end
        in_valid = 1'b0;
        test_go;
        test_load(1'b0);
        test_run;
        test_store(0);
    endtask

    initial begin
        rst_n     = 1'b0;
        go        = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        repeat (2) tick;
        test_reset;
        rst_n = 1'b1;
        tick;
        test_go;
        test_load(1'b0);
        test_run;
        test_store(0);
        test_go;
        test_load(1'b1);
        test_run;
        test_store_stall;
        test_store(1);
        test_reset_mid_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning element width.
REQ-002 SHALL have parameter RUN_CYCLES, default 10, meaning the number of cycles START is held during compute.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port go, input, 1 bit: start one full matrix job; sampled only in IDLE.
REQ-006 SHALL have port in_data, input, DATA_WIDTH bits: matrix element byte.
REQ-007 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: load handshake.
REQ-008 SHALL have port instruction, output, 16 bits: registered instruction word to the control unit.
REQ-009 SHALL have port result_in, input, DATA_WIDTH bits: array output for the currently addressed row/col (combinational from the array).
REQ-010 SHALL have port res_data, output, DATA_WIDTH bits: captured result.
REQ-011 SHALL have port res_valid, output, 1 bit, and port res_ready, input, 1 bit: result handshake.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at job end.

Function
REQ-014 Word encoding SHALL be [15:14] opcode (LOAD=10, STORE=11, START=00, STOP=01), [13] mem select (0=A, 1=B), [12]=0, [11:10] row, [9:8] col, [7:0] imm.
REQ-015 The idle word SHALL be STOP, 16'h4000, driven in every cycle not otherwise specified.
REQ-016 FSM states SHALL be IDLE, LOAD, RUN, STOP, ST_ADDR, ST_WAIT and DONE.
REQ-017 Transition IDLE->LOAD SHALL occur on go=1; go in any other state SHALL be ignored.
REQ-018 In LOAD, in_ready=1; in all other states in_ready=0.
REQ-019 Each LOAD handshake (in_valid&&in_ready) SHALL increment a 5-bit index idx (0..31).
REQ-020 For each LOAD handshake, the next cycle's instruction SHALL be LOAD with sel=idx[4], row=idx[3:2], col=idx[1:0] and imm=in_data; no-handshake cycles SHALL emit 16'h4000.
REQ-021 After the 32nd handshake (idx=31 accepted), the FSM SHALL enter RUN on the next edge; the last LOAD word appears in the first RUN cycle.
REQ-022 RUN SHALL drive 16'h0000 (START, all fields 0) for exactly RUN_CYCLES cycles, counted by a 4-bit counter, then enter STOP.
REQ-023 STOP SHALL drive 16'h4000 for one cycle, then enter ST_ADDR with store index sidx=0.
REQ-024 ST_ADDR SHALL drive STORE with row=sidx[3:2], col=sidx[1:0], imm=0 and sel=0 for one cycle.
REQ-025 At the edge leaving ST_ADDR, res_data SHALL capture result_in and res_valid SHALL rise; the FSM then enters ST_WAIT.
REQ-026 ST_WAIT SHALL hold the same STORE word and hold res_data/res_valid stable until res_ready=1.
REQ-027 On acceptance in ST_WAIT, res_valid SHALL fall and sidx SHALL increment, with a transition to ST_ADDR, or to DONE if sidx was 15.
REQ-028 DONE SHALL assert done=1 for one cycle, drive 16'h4000, and return to IDLE.
REQ-029 in_valid outside LOAD SHALL be ignored, and no byte SHALL be consumed.
REQ-030 Index counters SHALL never wrap mid-job; all counters SHALL clear on entry to LOAD.

Reset
REQ-031 On rst_n=0, the block SHALL immediately enter IDLE and set instruction=16'h4000, in_ready=0, res_valid=0, res_data=0, busy=0, done=0, and all counters to 0.
REQ-032 Reset asserted mid-job SHALL abort the job; after release, the next job SHALL require go and SHALL restart at idx=0.

Verification
REQ-033 go, then 32 back-to-back bytes with byte 6 (idx 5) = 0x12 -> instruction=16'h8512 one cycle after its accept; byte 17 (idx 16) = 0xAB -> 16'hA0AB.
REQ-034 Gaps in in_valid during LOAD -> 16'h4000 in gap cycles; no idx advance; 32 LOAD words total.
REQ-035 After the last byte -> exactly RUN_CYCLES cycles of 16'h0000, then one 16'h4000, then 16'hC000.
REQ-036 Store phase with res_ready tied 1 and result_in = 0x5A at sidx=11 -> STORE word 16'hCB00 and res_data=0x5A; 16 results delivered; done pulses once; busy falls.
REQ-037 Store phase with res_ready held 0 for 5 cycles -> res_data, res_valid and instruction stay constant; no sidx advance.
REQ-038 rst_n pulsed low during RUN -> instruction=16'h4000 immediately, busy=0; a later go restarts LOAD at idx 0.
